// File: rtl/axon_if.sv
// axon_if: output beat bundle from the axon transmitter to a downstream soma.
interface axon_if #(
    parameter int FANOUT = 4
);
    localparam int SW = $clog2(FANOUT);

    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_spike;
    logic [7:0]    out_weight;
    logic [SW-1:0] out_syn;

    modport master (
        output out_valid, out_spike, out_weight, out_syn,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_spike, out_weight, out_syn,
        output out_ready
    );
endinterface

// File: rtl/axon_tx.sv
// axon_tx: spike queue with optional delivery delay and weighted fan-out.
// Define AXON_DELAY_EN to enable the per-event delay countdown.
module axon_tx #(
    parameter int  DEPTH  = 4,
    parameter int  FANOUT = 4,
    localparam int SW     = $clog2(FANOUT),
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kill,
    input  logic [7:0]    axon_delay,
    input  logic          fire,
    input  logic [7:0]    spike_time,
    input  logic          w_we,
    input  logic [SW-1:0] w_addr,
    input  logic [7:0]    w_data,
    axon_if.master        out,
    output logic          o_full,
    output logic          o_drop
);
    typedef enum logic [1:0] {IDLE, DELAY, SEND, DEAD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    ts_mem [DEPTH];
    logic [7:0]    dl_mem [DEPTH];
    logic [7:0]    wtab_q [FANOUT];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] level_q;
    logic [7:0]    dcnt_q, dcnt_d;
    logic [7:0]    spike_q, spike_d;
    logic [7:0]    weight_q, weight_d;
    logic [SW-1:0] idx_q, idx_d;
    logic          drop_q;
    logic          push, pop, full, dead;
    logic [7:0]    ts_in, dl_in;

    assign full = (level_q == CW'(DEPTH));
    assign dead = (state_q == DEAD);
    assign push = fire && !full && !dead && !kill;

`ifdef AXON_DELAY_EN
    assign ts_in = spike_time + axon_delay;
    assign dl_in = axon_delay;
`else
    logic unused_dly;
    assign unused_dly = ^axon_delay;
    assign ts_in = spike_time;
    assign dl_in = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_q] <= ts_in;
            dl_mem[wr_q] <= dl_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        idx_d    = idx_q;
        spike_d  = spike_q;
        weight_d = weight_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    dcnt_d = dl_mem[rd_q];
`ifdef AXON_DELAY_EN
                    state_d = DELAY;
`else
                    state_d  = SEND;
                    idx_d    = '0;
                    spike_d  = ts_mem[rd_q];
                    weight_d = wtab_q[0];
`endif
                end
            end
            DELAY: begin
                if (dcnt_q == 8'd0) begin
                    state_d  = SEND;
                    idx_d    = '0;
                    spike_d  = ts_mem[rd_q];
                    weight_d = wtab_q[0];
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                end
            end
            SEND: begin
                if (out.out_ready) begin
                    if (idx_q == SW'(FANOUT - 1)) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d    = idx_q + SW'(1);
                        weight_d = wtab_q[idx_q + SW'(1)];
                    end
                end
            end
            DEAD: begin
            end
        endcase
        // Kill wins over everything, including a beat being accepted.
        if (kill) begin
            state_d = DEAD;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            dcnt_q   <= '0;
            idx_q    <= '0;
            spike_q  <= '0;
            weight_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            idx_q    <= idx_d;
            spike_q  <= spike_d;
            weight_q <= weight_d;
            drop_q   <= fire && full && !dead && !kill;
            if (kill) begin
                wr_q    <= '0;
                rd_q    <= '0;
                level_q <= '0;
            end else begin
                if (push)
                    wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
                if (pop)
                    rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
                if (push && !pop)
                    level_q <= level_q + CW'(1);
                else if (pop && !push)
                    level_q <= level_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FANOUT; i++)
                wtab_q[i] <= '0;
        end else if (w_we) begin
            wtab_q[w_addr] <= w_data;
        end
    end

    assign out.out_valid  = (state_q == SEND);
    assign out.out_spike  = spike_q;
    assign out.out_weight = weight_q;
    assign out.out_syn    = idx_q;
    assign o_full         = full;
    assign o_drop         = drop_q;
endmodule

// File: tb/tb_axon_tx.sv
// tb_axon_tx: scoreboard bench for axon_tx (DEPTH=4, FANOUT=4).
module tb_axon_tx;
`ifdef AXON_DELAY_EN
    localparam bit DLY = 1'b1;
`else
    localparam bit DLY = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] sp;
        logic [7:0] w;
        logic [1:0] syn;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kill = 1'b0;
    logic       fire = 1'b0;
    logic       w_we = 1'b0;
    logic [7:0] axon_delay = '0;
    logic [7:0] spike_time = '0;
    logic [7:0] w_data = '0;
    logic [1:0] w_addr = '0;
    logic       o_full, o_drop;

    beat_t      exp_q[$];
    beat_t      obs_q[$];
    logic [7:0] wt [4];
    int         n_cmp = 0;
    int         n_err = 0;

    axon_if #(.FANOUT(4)) bus ();

    axon_tx #(.DEPTH(4), .FANOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .kill       (kill),
        .axon_delay (axon_delay),
        .fire       (fire),
        .spike_time (spike_time),
        .w_we       (w_we),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .out        (bus),
        .o_full     (o_full),
        .o_drop     (o_drop)
    );

    always #5 clk = ~clk;

    function automatic beat_t cur();
        return {bus.out_spike, bus.out_weight, bus.out_syn};
    endfunction

    task automatic wr_w(input logic [1:0] a, input logic [7:0] d);
        w_we = 1'b1; w_addr = a; w_data = d;
        @(negedge clk);
        w_we = 1'b0;
        wt[a] = d;
    endtask

    task automatic do_fire(input logic [7:0] st, input logic [7:0] d,
                           input bit keep);
        logic [7:0] e;
        e = DLY ? st + d : st;
        fire = 1'b1; spike_time = st; axon_delay = d;
        if (keep)
            for (int i = 0; i < 4; i++)
                exp_q.push_back({e, wt[i], 2'(i)});
        @(negedge clk);
        fire = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        int t = 0;
        while (obs_q.size() < n && t < budget) begin
            if (bus.out_valid && bus.out_ready)
                obs_q.push_back(cur());
            if (obs_q.size() < n) begin
                @(negedge clk);
                t++;
            end
        end
    endtask

    task automatic wait_valid(input int budget);
        int t = 0;
        while (!bus.out_valid && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp += 6;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
        if (bus.out_spike !== 8'd0) begin n_err++; $display("FAIL rst_spike got %h want 00", bus.out_spike); end
        if (bus.out_weight !== 8'd0) begin n_err++; $display("FAIL rst_weight got %h want 00", bus.out_weight); end
        if (bus.out_syn !== 2'd0) begin n_err++; $display("FAIL rst_syn got %h want 0", bus.out_syn); end
        if (o_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", o_full); end
        if (o_drop !== 1'b0) begin n_err++; $display("FAIL rst_drop got %b want 0", o_drop); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_w(2'd0, 8'h21);
        wr_w(2'd1, 8'h42);
        wr_w(2'd2, 8'h63);
        wr_w(2'd3, 8'h84);
    endtask

    task automatic test_latency();
        int    lat;
        beat_t o, e;
        lat = DLY ? 3 + 2 : 1;
        bus.out_ready = 1'b1;
        obs_q.delete();
        do_fire(8'd10, 8'd3, 1'b1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== (k == lat)) begin
                n_err++;
                $display("FAIL lat_edge%0d valid got %b want %b", k, bus.out_valid, (k == lat));
            end
        end
        collect(4, 20);
        n_cmp++;
        if (obs_q.size() != 4) begin n_err++; $display("FAIL lat_count got %0d want 4", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL lat_beat got %h want %h", o, e); end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_gap valid got %b want 0", bus.out_valid); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        beat_t b, o;
        int    bad = 0;
        bus.out_ready = 1'b0;
        do_fire(8'd77, 8'd0, 1'b1);
        wait_valid(20);
        b = exp_q.pop_front(); n_cmp++;
        if (!bus.out_valid || cur() !== b) begin n_err++; $display("FAIL stall_syn0 got %h want %h", cur(), b); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        b = exp_q.pop_front(); n_cmp++;
        if (!bus.out_valid || cur() !== b) begin n_err++; $display("FAIL stall_syn1 got %h want %h", cur(), b); end
        repeat (6) begin
            @(negedge clk);
            if (!bus.out_valid || cur() !== b) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL stall_hold got %0d changes want 0", bad); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        b = exp_q.pop_front(); n_cmp++;
        if (!bus.out_valid || cur() !== b) begin n_err++; $display("FAIL stall_syn2 got %h want %h", cur(), b); end
        obs_q.delete();
        @(negedge clk);
        collect(1, 10);
        b = exp_q.pop_front(); o = obs_q.size() > 0 ? obs_q.pop_front() : '0; n_cmp++;
        if (o !== b) begin n_err++; $display("FAIL stall_syn3 got %h want %h", o, b); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overflow();
        beat_t o, e;
        int    nb = 0;
        bus.out_ready = 1'b0;
        do_fire(8'd1, 8'd1, 1'b1);
        do_fire(8'd2, 8'd1, 1'b1);
        do_fire(8'd3, 8'd1, 1'b1);
        n_cmp++;
        if (o_full !== 1'b0) begin n_err++; $display("FAIL ovf_full3 got %b want 0", o_full); end
        do_fire(8'd4, 8'd1, 1'b1);
        n_cmp++;
        if (o_full !== 1'b1) begin n_err++; $display("FAIL ovf_full4 got %b want 1", o_full); end
        do_fire(8'd5, 8'd1, 1'b0);
        n_cmp++;
        if (o_drop !== 1'b1) begin n_err++; $display("FAIL ovf_drop got %b want 1", o_drop); end
        @(negedge clk);
        n_cmp++;
        if (o_drop !== 1'b0) begin n_err++; $display("FAIL ovf_drop_end got %b want 0", o_drop); end
        bus.out_ready = 1'b1;
        obs_q.delete();
        collect(16, 300);
        n_cmp++;
        if (obs_q.size() != 16) begin n_err++; $display("FAIL ovf_count got %0d want 16", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL ovf_beat got %h want %h", o, e); end
        end
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) nb++;
        end
        n_cmp += 2;
        if (nb != 0) begin n_err++; $display("FAIL ovf_extra got %0d beats want 0", nb); end
        if (o_full !== 1'b0) begin n_err++; $display("FAIL ovf_full_end got %b want 0", o_full); end
    endtask

    task automatic test_wrap();
        beat_t o, e;
        bus.out_ready = 1'b1;
        obs_q.delete();
        do_fire(8'd250, 8'd10, 1'b1);
        collect(4, 40);
        n_cmp++;
        if (obs_q.size() != 4) begin n_err++; $display("FAIL wrap_count got %0d want 4", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL wrap_beat got %h want %h", o, e); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_kill();
        beat_t o, e;
        int    nb = 0;
        int    nd = 0;
        bus.out_ready = 1'b0;
        do_fire(8'd20, 8'd2, 1'b1);
        do_fire(8'd30, 8'd2, 1'b1);
        wait_valid(30);
        bus.out_ready = 1'b1;
        obs_q.delete();
        collect(2, 10);
        n_cmp++;
        if (obs_q.size() != 2) begin n_err++; $display("FAIL kill_pre got %0d want 2", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL kill_beat got %h want %h", o, e); end
        end
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (!bus.out_valid || cur() !== e) begin n_err++; $display("FAIL kill_syn2 got %h want %h", cur(), e); end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL kill_valid got %b want 0", bus.out_valid); end
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            do_fire(8'(40 + i), 8'd0, 1'b0);
            if (o_drop !== 1'b0) nd++;
        end
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) nb++;
            if (o_drop !== 1'b0) nd++;
        end
        n_cmp += 3;
        if (nb != 0) begin n_err++; $display("FAIL kill_beats got %0d want 0", nb); end
        if (nd != 0) begin n_err++; $display("FAIL kill_drop got %0d pulses want 0", nd); end
        if (o_full !== 1'b0) begin n_err++; $display("FAIL kill_full got %b want 0", o_full); end
    endtask

    task automatic test_reset_mid();
        beat_t o, e;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) wt[i] = 8'd0;
        @(negedge clk);
        wr_w(2'd0, 8'd5);
        wr_w(2'd1, 8'd6);
        wr_w(2'd2, 8'd7);
        wr_w(2'd3, 8'd8);
        bus.out_ready = 1'b1;
        obs_q.delete();
        do_fire(8'd99, 8'd1, 1'b1);
        collect(4, 40);
        n_cmp++;
        if (obs_q.size() != 4) begin n_err++; $display("FAIL rmid_pre got %0d want 4", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL rmid_pre_beat got %h want %h", o, e); end
        end
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_fire(8'd40, 8'd20, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp += 6;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", bus.out_valid); end
        if (bus.out_spike !== 8'd0) begin n_err++; $display("FAIL rmid_spike got %h want 00", bus.out_spike); end
        if (bus.out_weight !== 8'd0) begin n_err++; $display("FAIL rmid_weight got %h want 00", bus.out_weight); end
        if (bus.out_syn !== 2'd0) begin n_err++; $display("FAIL rmid_syn got %h want 0", bus.out_syn); end
        if (o_full !== 1'b0) begin n_err++; $display("FAIL rmid_full got %b want 0", o_full); end
        if (o_drop !== 1'b0) begin n_err++; $display("FAIL rmid_drop got %b want 0", o_drop); end
        for (int i = 0; i < 4; i++) wt[i] = 8'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        obs_q.delete();
        do_fire(8'd7, 8'd1, 1'b1);
        collect(4, 40);
        n_cmp++;
        if (obs_q.size() != 4) begin n_err++; $display("FAIL rmid_post got %0d want 4", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL rmid_beat got %h want %h", o, e); end
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wt[i] = 8'd0;
        test_reset();
        test_latency();
        test_stall();
        test_overflow();
        test_wrap();
        test_kill();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
